// File: rtl/rupt_pkg.sv
// Shared definitions for the AGC RUPT controller: state encoding, rank/flag
// maps and default vector layout.
package rupt_pkg;

    localparam int NUM_RUPTS = 6;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQUEST  = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    typedef enum logic [2:0] {
        RANK_T6   = 3'd0,
        RANK_T5   = 3'd1,
        RANK_T3   = 3'd2,
        RANK_T4   = 3'd3,
        RANK_KEY1 = 3'd4,
        RANK_KEY2 = 3'd5
    } rupt_rank_e;

    localparam logic [11:0] DEF_VECTOR_BASE   = 12'o4000;
    localparam int          DEF_VECTOR_STRIDE = 4;

    // Flag bit order from memory is T3,T4,T5,T6,KEY1,KEY2; rank order is AGC priority.
    function automatic logic [2:0] flag_to_rank(input logic [2:0] flag);
        case (flag)
            3'd0:    return 3'd2;
            3'd1:    return 3'd3;
            3'd2:    return 3'd1;
            3'd3:    return 3'd0;
            3'd4:    return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [2:0] rank_to_flag(input logic [2:0] rank);
        case (rank)
            3'd0:    return 3'd3;
            3'd1:    return 3'd2;
            3'd2:    return 3'd0;
            3'd3:    return 3'd1;
            3'd4:    return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [11:0] rupt_vector_addr(input logic [11:0] base,
                                                     input logic [11:0] stride,
                                                     input logic [2:0]  rank);
        return base + stride * ({9'd0, rank} + 12'd1);
    endfunction

endpackage

// File: rtl/rupt_priority.sv
// Combinational priority pick: lowest rank among the asserted flags wins.
module rupt_priority
    import rupt_pkg::*;
(
    input  logic [5:0] flags_i,
    output logic       valid_o,
    output rupt_rank_e rank_o,
    output logic [2:0] flag_idx_o
);

    logic [2:0] cand_rank;

    always_comb begin
        valid_o    = 1'b0;
        rank_o     = RANK_KEY2;
        flag_idx_o = 3'd5;
        cand_rank  = 3'd0;
        for (int i = 0; i < NUM_RUPTS; i++) begin
            cand_rank = flag_to_rank(3'(i));
            if (flags_i[i] && (!valid_o || (cand_rank < rank_o))) begin
                valid_o    = 1'b1;
                rank_o     = rupt_rank_e'(cand_rank);
                flag_idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/rupt_controller.sv
// RUPT arbiter/handshake: picks the pending timer/key interrupt, offers its
// vector to the CPU, clears the flag in memory on ack and watches ISR length.
module rupt_controller
    import rupt_pkg::*;
#(
    parameter logic [11:0] VECTOR_BASE      = DEF_VECTOR_BASE,
    parameter int          VECTOR_STRIDE    = DEF_VECTOR_STRIDE,
    parameter int          RUPT_LOCK_CYCLES = 840000
) (
    input  logic        clk_i,
    input  logic        reset_ni,          // active-low, asynchronous
    input  logic [5:0]  interrupt_flags_i,
    input  logic        interrupt_enable_i,
    input  logic        cpu_boundary_i,
    input  logic        cpu_blocked_i,
    input  logic        rupt_ack_i,
    input  logic        resume_i,
    input  logic        alarm_clear_i,
    output logic        rupt_request_o,
    output logic [11:0] rupt_vector_o,
    output logic [2:0]  rupt_number_o,
    output logic [5:0]  interrupt_clear_o,
    output logic        in_isr_o,
    output logic        rupt_lock_o
);

    localparam logic [19:0] LOCK_LAST = 20'(RUPT_LOCK_CYCLES - 1);
    localparam logic [19:0] CNT_MAX   = '1;

    logic [1:0]  state_q, state_d;
    logic [2:0]  rank_q, rank_d;
    logic [2:0]  flag_q, flag_d;
    logic [11:0] vector_q, vector_d;
    logic [5:0]  clear_q, clear_d;
    logic [19:0] lock_cnt_q, lock_cnt_d;
    logic        lock_q, lock_d;

    logic        pick_valid;
    rupt_rank_e  pick_rank;
    logic [2:0]  pick_flag;
    logic        take;

    rupt_priority u_priority (
        .flags_i    (interrupt_flags_i),
        .valid_o    (pick_valid),
        .rank_o     (pick_rank),
        .flag_idx_o (pick_flag)
    );

    assign take = interrupt_enable_i & ~cpu_blocked_i & cpu_boundary_i & pick_valid;

    always_comb begin
        state_d    = state_q;
        rank_d     = rank_q;
        flag_d     = flag_q;
        vector_d   = vector_q;
        clear_d    = '0;
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d  = ST_REQUEST;
                    rank_d   = pick_rank;
                    flag_d   = pick_flag;
                    vector_d = rupt_vector_addr(VECTOR_BASE, 12'(VECTOR_STRIDE), pick_rank);
                end
            end
            ST_REQUEST: begin
                // Ack beats a same-cycle enable drop; the latched flag is cleared even if it already fell.
                if (rupt_ack_i) begin
                    state_d    = ST_ACTIVE;
                    clear_d    = 6'd1 << flag_q;
                    lock_cnt_d = '0;
                end else if (!interrupt_enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + 20'd1;
                if (resume_i) state_d = ST_COOLDOWN;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_ACTIVE) && (lock_cnt_q == LOCK_LAST)) lock_d = 1'b1;
        else if (alarm_clear_i)                                   lock_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            rank_q     <= '0;
            flag_q     <= '0;
            vector_q   <= '0;
            clear_q    <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rank_q     <= rank_d;
            flag_q     <= flag_d;
            vector_q   <= vector_d;
            clear_q    <= clear_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign rupt_request_o    = (state_q == ST_REQUEST);
    assign in_isr_o          = (state_q == ST_ACTIVE);
    assign rupt_vector_o     = vector_q;
    assign rupt_number_o     = rank_q;
    assign interrupt_clear_o = clear_q;
    assign rupt_lock_o       = lock_q;

endmodule

// File: tb/tb_rupt_controller.sv
// Bench for rupt_controller: directed scenarios plus random traffic against a
// behavioural model of the RUPT handshake.
module tb_rupt_controller;

    localparam int LOCK = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  flags = '0;
    logic        en = 1'b0, bnd = 1'b0, blk = 1'b0, ack = 1'b0, resume = 1'b0, aclr = 1'b0;
    logic        rupt_request, in_isr, rupt_lock;
    logic [11:0] rupt_vector;
    logic [2:0]  rupt_number;
    logic [5:0]  interrupt_clear;

    int n_chk = 0;
    int n_pass = 0;

    rupt_controller #(.RUPT_LOCK_CYCLES(LOCK)) dut (
        .clk_i              (clk),
        .reset_ni           (rst_n),
        .interrupt_flags_i  (flags),
        .interrupt_enable_i (en),
        .cpu_boundary_i     (bnd),
        .cpu_blocked_i      (blk),
        .rupt_ack_i         (ack),
        .resume_i           (resume),
        .alarm_clear_i      (aclr),
        .rupt_request_o     (rupt_request),
        .rupt_vector_o      (rupt_vector),
        .rupt_number_o      (rupt_number),
        .interrupt_clear_o  (interrupt_clear),
        .in_isr_o           (in_isr),
        .rupt_lock_o        (rupt_lock)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 waiting, 1 offered to CPU, 2 serving ISR, 3 settling.
    int          m_phase = 0;
    int          m_rank = 0;
    int          m_served = 0;
    logic [11:0] m_vec = '0;
    logic [5:0]  m_clr = '0;
    bit          m_lock = 0;
    int          flag_of_rank [6] = '{3, 2, 0, 1, 4, 5};

    function automatic void model_reset();
        m_phase = 0; m_rank = 0; m_served = 0; m_vec = '0; m_clr = '0; m_lock = 0;
    endfunction

    function automatic void model_step();
        bit set_lock = 0;
        m_clr = '0;
        case (m_phase)
            0: if (en && !blk && bnd && flags != 0) begin
                for (int r = 5; r >= 0; r--) if (flags[flag_of_rank[r]]) m_rank = r;
                m_vec = 12'(12'o4000 + 4 * (m_rank + 1));
                m_phase = 1;
            end
            1: if (ack) begin
                m_phase = 2; m_served = 0; m_clr[flag_of_rank[m_rank]] = 1'b1;
            end else if (!en) m_phase = 0;
            2: begin
                m_served++;
                if (m_served == LOCK) set_lock = 1;
                if (resume) m_phase = 3;
            end
            default: m_phase = 0;
        endcase
        if (set_lock) m_lock = 1;
        else if (aclr) m_lock = 0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (rupt_request !== 1'b0) $display("FAIL reset_req got %b want 0", rupt_request); else n_pass++;
        n_chk++; if (rupt_vector !== 12'd0) $display("FAIL reset_vec got %o want 0", rupt_vector); else n_pass++;
        n_chk++; if (rupt_number !== 3'd0) $display("FAIL reset_num got %0d want 0", rupt_number); else n_pass++;
        n_chk++; if (interrupt_clear !== 6'd0) $display("FAIL reset_clr got %b want 0", interrupt_clear); else n_pass++;
        n_chk++; if ({in_isr, rupt_lock} !== 2'b00) $display("FAIL reset_isr_lock got %b want 00", {in_isr, rupt_lock}); else n_pass++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_t6();
        flags = 6'b001000; en = 1; bnd = 1;
        tick();
        n_chk++; if (rupt_request !== 1'b1) $display("FAIL t6_req got %b want 1", rupt_request); else n_pass++;
        n_chk++; if (rupt_vector !== 12'o4004) $display("FAIL t6_vec got %o want 4004", rupt_vector); else n_pass++;
        n_chk++; if (rupt_number !== 3'd0) $display("FAIL t6_num got %0d want 0", rupt_number); else n_pass++;
        bnd = 0; ack = 1;
        tick();
        n_chk++; if (interrupt_clear !== 6'b001000) $display("FAIL t6_clr got %b want 001000", interrupt_clear); else n_pass++;
        n_chk++; if ({rupt_request, in_isr} !== 2'b01) $display("FAIL t6_active got %b want 01", {rupt_request, in_isr}); else n_pass++;
        ack = 0; flags = 0;
        tick();
        n_chk++; if (interrupt_clear !== 6'd0) $display("FAIL t6_clr_pulse got %b want 0", interrupt_clear); else n_pass++;
        resume = 1;
        tick();
        n_chk++; if (in_isr !== 1'b0) $display("FAIL t6_resume got %b want 0", in_isr); else n_pass++;
        resume = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        flags = 6'b000011; en = 1; bnd = 1;
        tick();
        n_chk++; if (rupt_vector !== 12'o4014) $display("FAIL b2b_vec1 got %o want 4014", rupt_vector); else n_pass++;
        n_chk++; if (rupt_number !== 3'd2) $display("FAIL b2b_num1 got %0d want 2", rupt_number); else n_pass++;
        ack = 1;
        tick();
        n_chk++; if (interrupt_clear !== 6'b000001) $display("FAIL b2b_clr1 got %b want 000001", interrupt_clear); else n_pass++;
        ack = 0; flags = 6'b000010; resume = 1;
        tick();
        n_chk++; if ({rupt_request, in_isr} !== 2'b00) $display("FAIL b2b_cool got %b want 00", {rupt_request, in_isr}); else n_pass++;
        resume = 0;
        tick();
        n_chk++; if (rupt_request !== 1'b0) $display("FAIL b2b_gap got %b want 0", rupt_request); else n_pass++;
        tick();
        n_chk++; if (rupt_request !== 1'b1) $display("FAIL b2b_req2 got %b want 1", rupt_request); else n_pass++;
        n_chk++; if (rupt_vector !== 12'o4020) $display("FAIL b2b_vec2 got %o want 4020", rupt_vector); else n_pass++;
        ack = 1;
        tick();
        n_chk++; if (interrupt_clear !== 6'b000010) $display("FAIL b2b_clr2 got %b want 000010", interrupt_clear); else n_pass++;
        ack = 0; flags = 0; resume = 1;
        tick();
        resume = 0;
        tick();
    endtask

    task automatic test_blocked_withdraw();
        flags = 6'b000100; en = 1; bnd = 1; blk = 1;
        repeat (3) tick();
        n_chk++; if (rupt_request !== 1'b0) $display("FAIL blk_held got %b want 0", rupt_request); else n_pass++;
        blk = 0; bnd = 0;
        tick();
        n_chk++; if (rupt_request !== 1'b0) $display("FAIL blk_noboundary got %b want 0", rupt_request); else n_pass++;
        bnd = 1;
        tick();
        n_chk++; if (rupt_vector !== 12'o4010 || rupt_request !== 1'b1) $display("FAIL blk_vec got %o/%b want 4010/1", rupt_vector, rupt_request); else n_pass++;
        en = 0;
        tick();
        n_chk++; if ({rupt_request, in_isr, interrupt_clear} !== 8'd0) $display("FAIL withdraw got %b want 0", {rupt_request, in_isr, interrupt_clear}); else n_pass++;
        en = 1;
        tick();
        n_chk++; if (rupt_request !== 1'b1) $display("FAIL withdraw_rereq got %b want 1", rupt_request); else n_pass++;
        en = 0; ack = 1;
        tick();
        n_chk++; if ({in_isr, interrupt_clear} !== 7'b1000100) $display("FAIL ack_wins got %b want 1000100", {in_isr, interrupt_clear}); else n_pass++;
        ack = 0; en = 1; flags = 0; resume = 1;
        tick();
        resume = 0;
        tick();
    endtask

    task automatic test_lock();
        flags = 6'b001000; en = 1; bnd = 1;
        tick();
        ack = 1;
        tick();
        ack = 0; flags = 0;
        repeat (LOCK - 1) tick();
        n_chk++; if (rupt_lock !== 1'b0) $display("FAIL lock_early got %b want 0", rupt_lock); else n_pass++;
        tick();
        n_chk++; if (rupt_lock !== 1'b1) $display("FAIL lock_set got %b want 1", rupt_lock); else n_pass++;
        repeat (4) tick();
        resume = 1;
        tick();
        resume = 0;
        tick();
        n_chk++; if ({rupt_lock, in_isr} !== 2'b10) $display("FAIL lock_sticky got %b want 10", {rupt_lock, in_isr}); else n_pass++;
        aclr = 1;
        tick();
        aclr = 0;
        n_chk++; if (rupt_lock !== 1'b0) $display("FAIL lock_clear got %b want 0", rupt_lock); else n_pass++;
    endtask

    task automatic test_async_reset();
        flags = 6'b000001; en = 1; bnd = 1;
        tick();
        ack = 1;
        tick();
        ack = 0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++; if ({rupt_request, in_isr, rupt_lock, interrupt_clear} !== 9'd0) $display("FAIL arst_outs got %b want 0", {rupt_request, in_isr, rupt_lock, interrupt_clear}); else n_pass++;
        n_chk++; if ({rupt_vector, rupt_number} !== 15'd0) $display("FAIL arst_vec got %o want 0", {rupt_vector, rupt_number}); else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        n_chk++; if (rupt_request !== 1'b1 || rupt_vector !== 12'o4014) $display("FAIL arst_rereq got %b/%o want 1/4014", rupt_request, rupt_vector); else n_pass++;
        ack = 1;
        tick();
        ack = 0; flags = 0; resume = 1;
        tick();
        resume = 0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) flags = 6'($urandom);
            en     = ($urandom_range(0, 7) != 0);
            blk    = ($urandom_range(0, 3) == 0);
            bnd    = ($urandom_range(0, 1) == 1);
            ack    = ($urandom_range(0, 2) == 0);
            resume = ($urandom_range(0, 24) == 0);
            aclr   = ($urandom_range(0, 29) == 0);
            tick();
            n_chk++; if (rupt_request !== (m_phase == 1)) $display("FAIL rnd_req c=%0d got %b want %b", c, rupt_request, m_phase == 1); else n_pass++;
            n_chk++; if (in_isr !== (m_phase == 2)) $display("FAIL rnd_isr c=%0d got %b want %b", c, in_isr, m_phase == 2); else n_pass++;
            n_chk++; if (rupt_vector !== m_vec || rupt_number !== 3'(m_rank)) $display("FAIL rnd_vec c=%0d got %o/%0d want %o/%0d", c, rupt_vector, rupt_number, m_vec, m_rank); else n_pass++;
            n_chk++; if (interrupt_clear !== m_clr) $display("FAIL rnd_clr c=%0d got %b want %b", c, interrupt_clear, m_clr); else n_pass++;
            n_chk++; if (rupt_lock !== m_lock) $display("FAIL rnd_lock c=%0d got %b want %b", c, rupt_lock, m_lock); else n_pass++;
        end
        {ack, resume, aclr, blk} = '0;
    endtask

    initial begin
        test_reset();
        test_single_t6();
        test_back_to_back();
        test_blocked_withdraw();
        test_lock();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
